// File: rtl/scan_pkg.sv
// Shared types for the minterm scanner: FSM state encoding and vector range helper.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DRAIN  = 2'd3
  } scan_state_e;

  function automatic logic [31:0] max_vector(input int unsigned n_vars);
    return (32'd1 << n_vars) - 32'd1;
  endfunction

endpackage

// File: rtl/minterm_fifo.sv
// Small synchronous FIFO for minterm indices; registered output, no fall-through.
module minterm_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push on a full FIFO is accepted.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/minterm_scanner.sv
// Sweeps all input vectors of an N_VARS-input function and streams the indices where F=1.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last scan result
// DRIVE  | vector applied, settle counter running
// SAMPLE | F sampled; push on 1, stall while FIFO full
// DRAIN  | sweep finished, waiting for the FIFO to empty
module minterm_scanner
  import scan_pkg::*;
#(
  parameter int N_VARS     = 10,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_VARS-1:0] x_out,
  input  logic              f_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic              busy,
  output logic              done,
  output logic [N_VARS:0]   on_count
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_VARS-1:0] MAX_VEC = N_VARS'(max_vector(N_VARS));
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  scan_state_e       r_state;
  logic [N_VARS:0]   r_vec;
  logic [SW-1:0]     r_settle;
  logic [N_VARS:0]   r_on_count;
  logic              r_busy;
  logic              r_done;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_sample_done;
  logic              w_last;

  assign x_out    = r_vec[N_VARS-1:0];
  assign busy     = r_busy;
  assign done     = r_done;
  assign on_count = r_on_count;
  assign m_valid  = ~w_empty;

  assign w_last        = (r_vec == {1'b0, MAX_VEC});
  assign w_pop         = ~w_empty & m_ready;
  assign w_push        = (r_state == SAMPLE) & f_in & (~w_full | w_pop);
  assign w_sample_done = (r_state == SAMPLE) & (~f_in | ~w_full | w_pop);

  minterm_fifo #(
    .WIDTH (N_VARS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (x_out),
    .pop       (w_pop),
    .pop_data  (m_index),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_settle   <= '0;
      r_on_count <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !r_done) begin
            r_vec      <= '0;
            r_on_count <= '0;
            r_settle   <= '0;
            r_busy     <= 1'b1;
            r_state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_settle == SETTLE_LAST) r_state <= SAMPLE;
          else                         r_settle <= r_settle + 1'b1;
        end
        SAMPLE: begin
          if (w_push) r_on_count <= r_on_count + 1'b1;
          if (w_sample_done) begin
            if (w_last) begin
              r_state <= DRAIN;
            end else begin
              r_vec    <= r_vec + 1'b1;
              r_settle <= '0;
              r_state  <= DRIVE;
            end
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
